// File: rtl/rgb_filter_pkg.sv
// Shared definitions for the RGB colour filters: the mode encoding, the BT.601-style
// luma coefficients and the sideband that travels with each pixel.
package rgb_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GREY   = 2'd1,
    MODE_GREEN  = 2'd2,
    MODE_AMBER  = 2'd3
  } mode_t;

  // Coefficients sum to 1 << LUMA_SHIFT, so luma can never exceed full scale.
  localparam int unsigned LUMA_COEF_R = 77;
  localparam int unsigned LUMA_COEF_G = 150;
  localparam int unsigned LUMA_COEF_B = 29;
  localparam int unsigned LUMA_SHIFT  = 8;

  typedef struct packed {
    logic  hs;
    logic  vs;
    logic  de;
    logic  scan;
    logic  par;
    mode_t mode;
  } side_t;

  function automatic mode_t to_mode(input logic [1:0] i_code);
    return mode_t'(i_code);
  endfunction

endpackage

// File: rtl/rgb_luma.sv
// Two-stage luma pipe: stage 1 registers the three weighted products,
// stage 2 registers their sum scaled back to WIDTH bits.
module rgb_luma
  import rgb_filter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  localparam int ACC_W = WIDTH + LUMA_SHIFT;

  logic [ACC_W-1:0] w_pr;
  logic [ACC_W-1:0] w_pg;
  logic [ACC_W-1:0] w_pb;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] r_pr;
  logic [ACC_W-1:0] r_pg;
  logic [ACC_W-1:0] r_pb;

  assign w_pr  = ACC_W'(i_r) * ACC_W'(LUMA_COEF_R);
  assign w_pg  = ACC_W'(i_g) * ACC_W'(LUMA_COEF_G);
  assign w_pb  = ACC_W'(i_b) * ACC_W'(LUMA_COEF_B);
  assign w_sum = r_pr + r_pg + r_pb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pr <= '0;
      r_pg <= '0;
      r_pb <= '0;
      o_y  <= '0;
    end else if (i_ce) begin
      r_pr <= w_pr;
      r_pg <= w_pg;
      r_pb <= w_pb;
      o_y  <= w_sum[ACC_W-1:LUMA_SHIFT];
    end
  end

endmodule

// File: rtl/rgb_mono_pipe.sv
// Pipelined monochrome/retro filter: luma in rgb_luma (stages 1-2), then mode
// select, scanline dimming and blanking in stage 3. Three ce-cycles of latency.
module rgb_mono_pipe
  import rgb_filter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LATENCY_FIX = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic [1:0]       i_mode,
  input  logic             i_scanline,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_b,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de
);

  if (LATENCY_FIX != 3) begin : g_latency_check
    $error("rgb_mono_pipe: LATENCY_FIX must be 3");
  end

  logic             r_hs_d;
  logic             r_vs_d;
  logic             r_hist_vld;
  mode_t            r_mode;
  logic             r_par;

  logic             w_hs_rise;
  logic             w_vs_rise;
  mode_t            w_mode_nxt;
  logic             w_par_nxt;

  logic [WIDTH-1:0] r_s1_r;
  logic [WIDTH-1:0] r_s1_g;
  logic [WIDTH-1:0] r_s1_b;
  side_t            r_s1_side;
  logic [WIDTH-1:0] r_s2_r;
  logic [WIDTH-1:0] r_s2_g;
  logic [WIDTH-1:0] r_s2_b;
  side_t            r_s2_side;
  logic [WIDTH-1:0] w_y;

  logic [WIDTH-1:0] w_c3_r;
  logic [WIDTH-1:0] w_c3_g;
  logic [WIDTH-1:0] w_c3_b;

  // History is only trusted after one ce cycle, so a sync that is already
  // high when reset releases is not mistaken for an edge.
  assign w_hs_rise = r_hist_vld & i_hs & ~r_hs_d;
  assign w_vs_rise = r_hist_vld & i_vs & ~r_vs_d;

  // The pixel on an edge cycle already sees the updated mode and parity.
  assign w_mode_nxt = w_vs_rise ? to_mode(i_mode) : r_mode;
  assign w_par_nxt  = w_vs_rise ? 1'b0 : (w_hs_rise ? ~r_par : r_par);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_d     <= 1'b0;
      r_vs_d     <= 1'b0;
      r_hist_vld <= 1'b0;
      r_mode     <= MODE_BYPASS;
      r_par      <= 1'b0;
    end else if (i_ce) begin
      r_hs_d     <= i_hs;
      r_vs_d     <= i_vs;
      r_hist_vld <= 1'b1;
      r_mode     <= w_mode_nxt;
      r_par      <= w_par_nxt;
    end
  end

  rgb_luma #(
    .WIDTH (WIDTH)
  ) u_luma (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ce    (i_ce),
    .i_r     (i_r),
    .i_g     (i_g),
    .i_b     (i_b),
    .o_y     (w_y)
  );

  // NOTE: pipeline registers are reset too, so the first outputs after reset
  // release are defined zeros rather than X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_r    <= '0;
      r_s1_g    <= '0;
      r_s1_b    <= '0;
      r_s1_side <= '0;
      r_s2_r    <= '0;
      r_s2_g    <= '0;
      r_s2_b    <= '0;
      r_s2_side <= '0;
    end else if (i_ce) begin
      r_s1_r    <= i_r;
      r_s1_g    <= i_g;
      r_s1_b    <= i_b;
      r_s1_side <= '{hs: i_hs, vs: i_vs, de: i_de, scan: i_scanline,
                     par: w_par_nxt, mode: w_mode_nxt};
      r_s2_r    <= r_s1_r;
      r_s2_g    <= r_s1_g;
      r_s2_b    <= r_s1_b;
      r_s2_side <= r_s1_side;
    end
  end

  // NOTE: every always_comb output gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    w_c3_r = r_s2_r;
    w_c3_g = r_s2_g;
    w_c3_b = r_s2_b;
    case (r_s2_side.mode)
      MODE_GREY: begin
        w_c3_r = w_y;
        w_c3_g = w_y;
        w_c3_b = w_y;
      end
      MODE_GREEN: begin
        w_c3_r = '0;
        w_c3_g = w_y;
        w_c3_b = '0;
      end
      MODE_AMBER: begin
        w_c3_r = w_y;
        w_c3_g = w_y - (w_y >> 2);
        w_c3_b = '0;
      end
      default: ;
    endcase
    if (r_s2_side.scan && r_s2_side.par) begin
      w_c3_r = w_c3_r >> 1;
      w_c3_g = w_c3_g >> 1;
      w_c3_b = w_c3_b >> 1;
    end
    if (!r_s2_side.de) begin
      w_c3_r = '0;
      w_c3_g = '0;
      w_c3_b = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_hs <= 1'b0;
      o_vs <= 1'b0;
      o_de <= 1'b0;
    end else if (i_ce) begin
      o_r  <= w_c3_r;
      o_g  <= w_c3_g;
      o_b  <= w_c3_b;
      o_hs <= r_s2_side.hs;
      o_vs <= r_s2_side.vs;
      o_de <= r_s2_side.de;
    end
  end

endmodule

// File: tb/tb_rgb_mono_pipe.sv
// Directed bench for rgb_mono_pipe: a behavioural model pushes the expected pixel
// into a scoreboard queue when it is driven; it is popped three ce-cycles later.
module tb_rgb_mono_pipe;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       scan = 1'b0;
  logic [7:0] o_r, o_g, o_b;
  logic       o_hs, o_vs, o_de;

  pix_t  sb[$];
  pix_t  last_exp;
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  logic [1:0] m_mode;
  logic       m_par, m_hs_d, m_vs_d, m_vld;

  rgb_mono_pipe #(
    .WIDTH       (8),
    .LATENCY_FIX (3)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ce       (ce),
    .i_r        (r),
    .i_g        (g),
    .i_b        (b),
    .i_hs       (hs),
    .i_vs       (vs),
    .i_de       (de),
    .i_mode     (mode),
    .i_scanline (scan),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de)
  );

  always #5 clk = ~clk;

  task automatic check(input pix_t exp);
    pix_t obs;
    obs = {o_r, o_g, o_b, o_hs, o_vs, o_de};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed rgb=%0d,%0d,%0d hs/vs/de=%b%b%b expected rgb=%0d,%0d,%0d hs/vs/de=%b%b%b",
             tag, obs.r, obs.g, obs.b, obs.hs, obs.vs, obs.de,
             exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.de);
    end
  endtask

  // One clock with the currently driven inputs; model updates only on ce.
  task automatic tick();
    pix_t e;
    int   y;
    logic hr, vr;
    if (ce) begin
      hr = m_vld & hs & ~m_hs_d;
      vr = m_vld & vs & ~m_vs_d;
      if (vr) m_mode = mode;
      if (vr) m_par = 1'b0;
      else if (hr) m_par = ~m_par;
      m_hs_d = hs;
      m_vs_d = vs;
      m_vld  = 1'b1;
      y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) >> 8;
      case (m_mode)
        2'd0: begin e.r = r; e.g = g; e.b = b; end
        2'd1: begin e.r = 8'(y); e.g = 8'(y); e.b = 8'(y); end
        2'd2: begin e.r = 8'd0; e.g = 8'(y); e.b = 8'd0; end
        default: begin e.r = 8'(y); e.g = 8'(y - (y >> 2)); e.b = 8'd0; end
      endcase
      if (scan && m_par) begin
        e.r = e.r >> 1;
        e.g = e.g >> 1;
        e.b = e.b >> 1;
      end
      if (!de) begin
        e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
      end
      e.hs = hs;
      e.vs = vs;
      e.de = de;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (ce) last_exp = sb.pop_front();
    check(last_exp);
  endtask

  task automatic px(input logic [7:0] pr, pg, pb, input int n = 1);
    r = pr; g = pg; b = pb;
    repeat (n) tick();
  endtask

  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) #2;
    rst_n = 1'b0;
    ce = 1'b0;
    #1;
    tag = "reset_async";
    check('0);
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    last_exp = '0;
    m_mode = 2'd0; m_par = 1'b0; m_hs_d = 1'b0; m_vs_d = 1'b0; m_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tag = "reset_held";
    check('0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tag = "reset_release";
    check('0);
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  task automatic hs_pulse();
    hs = 1'b1; tick();
    hs = 1'b0; tick();
  endtask

  initial begin
    do_reset(1'b0);

    // Grey primaries after loading mode 1 at a vsync edge.
    ce = 1'b1; de = 1'b1; mode = 2'd1;
    tag = "grey_load";  vs_pulse();
    tag = "grey_white"; px(8'd255, 8'd255, 8'd255);
    tag = "grey_red";   px(8'd255, 8'd0,   8'd0);
    tag = "grey_green"; px(8'd0,   8'd255, 8'd0);
    tag = "grey_blue";  px(8'd0,   8'd0,   8'd255);
    tag = "grey_mix";   px(8'd10,  8'd200, 8'd90, 3);

    // Mid-frame mode request is ignored until the next vsync edge.
    mode = 2'd3;
    tag = "mode_hold";  px(8'd255, 8'd255, 8'd255, 4);
    tag = "amber_load"; vs_pulse();
    tag = "amber_white"; px(8'd255, 8'd255, 8'd255, 4);

    // Green phosphor on a mixed colour.
    mode = 2'd2;
    tag = "green_load"; vs_pulse();
    tag = "green_mix";  px(8'd120, 8'd60, 8'd240, 4);

    // Scanline parity: toggles per hsync, cleared when vsync coincides.
    mode = 2'd1; scan = 1'b1;
    tag = "scan_load";  vs_pulse();
    tag = "scan_line0"; px(8'd255, 8'd255, 8'd255, 3);
    tag = "scan_hs1";   hs_pulse(); px(8'd255, 8'd255, 8'd255, 3);
    tag = "scan_hs2";   hs_pulse(); px(8'd255, 8'd255, 8'd255, 3);
    tag = "scan_hs3";   hs_pulse(); px(8'd255, 8'd255, 8'd255, 3);
    tag = "scan_vs_hs"; hs = 1'b1; vs = 1'b1; tick(); hs = 1'b0; vs = 1'b0; tick();
    tag = "scan_after"; px(8'd255, 8'd255, 8'd255, 4);
    scan = 1'b0;

    // Pixel enable toggling 1,0,1,0: outputs move only on ce cycles.
    mode = 2'd0;
    tag = "ce_load"; vs_pulse();
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      tag = "ce_toggle";
      px(8'(i * 17), 8'(i * 5 + 3), 8'(255 - i * 9));
    end
    ce = 1'b1;
    tag = "ce_flush"; px(8'd1, 8'd2, 8'd3, 3);

    // Blanked input in bypass: colour zero, sync delayed as usual.
    de = 1'b0;
    tag = "blank";
    for (int i = 0; i < 6; i++) begin
      hs = i[0];
      vs = (i >= 3);
      px(8'd200, 8'd100, 8'd50);
    end
    hs = 1'b0; vs = 1'b0; de = 1'b1;
    tag = "bypass_de"; px(8'd200, 8'd100, 8'd50, 4);

    // Reset mid-line in amber, released with vsync already high.
    mode = 2'd3;
    tag = "amber_pre";  vs_pulse(); px(8'd255, 8'd255, 8'd255, 4);
    vs = 1'b1;
    do_reset(1'b1);
    ce = 1'b1;
    tag = "post_rst_bypass"; px(8'd255, 8'd255, 8'd255, 5);
    vs = 1'b0;
    tag = "post_rst_bypass2"; px(8'd255, 8'd255, 8'd255, 2);
    tag = "post_rst_amber"; vs_pulse(); px(8'd255, 8'd255, 8'd255, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_mono_pipe.md
RGB_MONO_PIPE -- requirements
Module: rgb_mono_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per colour channel, in and out.
REQ-002 SHALL have parameter LATENCY_FIX, default 3: pixel-enable cycles from input to output. Only 3 is legal.
REQ-003 SHALL have port i_clk, input, 1: the single clock. All logic uses its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_ce, input, 1: pixel enable. State advances only when it is high.
REQ-006 SHALL have ports i_r, i_g, i_b, input, WIDTH each: input colour.
REQ-007 SHALL have ports i_hs, i_vs, i_de, input, 1 each: active-high sync and data enable.
REQ-008 SHALL have port i_mode, input, 2: requested mode. 0 = bypass, 1 = grey, 2 = green phosphor, 3 = amber.
REQ-009 SHALL have port i_scanline, input, 1: enables odd-line dimming.
REQ-010 SHALL have ports o_r, o_g, o_b, output, WIDTH each: processed colour.
REQ-011 SHALL have ports o_hs, o_vs, o_de, output, 1 each: sync and data enable delayed to match the colour path.

Function
REQ-012 SHALL register all outputs. Latency SHALL be exactly 3 i_ce-qualified cycles for colour, sync and de alike.
REQ-013 SHALL hold all pipeline stages when i_ce = 0.
REQ-014 SHALL compute luma Y = (77*R + 150*G + 29*B) >> 8. Use an unsigned WIDTH+8-bit accumulator; there is no saturation because coefficients sum to 256 and Y never exceeds 2^WIDTH-1.
REQ-015 Per active mode, outputs SHALL be:
- bypass: R, G, B
- grey: Y, Y, Y
- green phosphor: 0, Y, 0
- amber: Y, Y - (Y >> 2), 0
REQ-016 SHALL apply the active mode, not i_mode. The active mode SHALL load from i_mode only on a rising edge of i_vs seen with i_ce = 1. Mid-frame changes take effect at the next frame.
REQ-017 SHALL keep a line-parity bit:
- cleared on each i_vs rising edge;
- otherwise toggled on each i_hs rising edge;
- both edges qualified by i_ce;
- when both occur together, the clear wins.
REQ-018 When i_scanline = 1 and parity = 1, the stage-3 result SHALL be shifted right by 1 on all channels. i_scanline is sampled at stage 1 and travels with the pixel.
REQ-019 Output colour SHALL be forced to 0 when the delayed de is 0, whatever the mode.
REQ-020 Edge detection SHALL use registered copies of i_hs and i_vs. The first cycle after reset SHALL NOT report an edge if the input is already high.

Reset
REQ-021 While i_rst_n = 0, the following SHALL be cleared asynchronously:
- all o_* outputs to 0;
- active mode to 0 (bypass);
- parity to 0;
- sync history registers and pipeline registers to 0.
REQ-022 Deassertion mid-frame SHALL resume in bypass until the next i_vs rising edge.
REQ-023 Output SHALL be valid, with no X, from the first i_ce cycle after reset release.

Structure
REQ-024 A shared package rgb_filter_pkg SHALL hold:
- the mode constants MODE_BYPASS, MODE_GREY, MODE_GREEN, MODE_AMBER;
- the luma coefficients 77, 150 and 29, with shift 8.
REQ-025 The luma computation SHALL be the sub-module rgb_luma (WIDTH parameter, i_ce, 2-stage multiply and sum pipe). Mode select, scanline and blanking form stage 3 in rgb_mono_pipe.
REQ-026 The existing combinational grey block SHALL stay unchanged. rgb_mono_pipe is a separate successor.

Verification
REQ-027 Mode grey, WIDTH 8, i_ce always 1, de = 1:
- (255,255,255) -> 255,255,255;
- (255,0,0) -> 76,76,76;
- (0,255,0) -> 149,149,149;
- (0,0,255) -> 28,28,28;
- each exactly 3 cycles after input.
REQ-028 Change i_mode from 1 to 3 mid-frame. Output SHALL stay grey until the next i_vs rising edge; after it, white -> 255,192,0.
REQ-029 i_scanline = 1, mode grey, white input:
- line 0 -> 255;
- after one i_hs rising edge -> 127;
- after the second -> 255;
- an i_vs edge coincident with an i_hs edge -> parity 0.
REQ-030 i_ce toggling 1,0,1,0: the output SHALL change only on ce cycles, with latency of 3 ce cycles.
REQ-031 de = 0 with input (200,100,50) in bypass -> 0,0,0, while o_hs and o_vs follow the input delayed by 3 cycles.
REQ-032 Assert i_rst_n low mid-line in amber mode. All outputs SHALL be 0 immediately; after release with mode 3 requested, output SHALL be bypass until the next vsync.
